instr_exec_queue: RTL and testbench

- Parametrised successor to the fixed-size instruction register file.
- An in-order instruction queue: each entry holds an opcode and two signed operands.
- The result is computed at enqueue time and stored with the entry.
- Valid/ready handshakes on both sides, a head-relative peek port, flush, and a saturating drop counter.
- Sits between the instruction generator/testbench driver and the downstream checker or execution stage.

---
 rtl/instr_register_pkg.sv | 18 +
 rtl/instr_alu.sv | 48 ++++
 rtl/instr_exec_queue.sv | 132 +++++++++++++
 tb/tb_instr_exec_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction queue and its ALU.
// Opcode encoding and default sizing.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU; result is twice the operand width.
// Division/modulo by zero yields 0 and raises err.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   a,
  input  logic signed [OP_WIDTH-1:0]   b,
  output logic signed [2*OP_WIDTH-1:0] result,
  output logic                         err
);

  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] ax;
  logic signed [RW-1:0] bx;
  logic                 bzero;

  assign ax    = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
  assign bx    = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};
  assign bzero = (b == '0);

  // Widened arithmetic keeps products and MIN/-1 exact
  always_comb begin
    result = '0;
    err    = 1'b0;
    unique case (opcode)
      ZERO:  result = '0;
      PASSA: result = ax;
      PASSB: result = bx;
      ADD:   result = ax + bx;
      SUB:   result = ax - bx;
      MULT:  result = ax * bx;
      DIV: begin
        if (bzero) err = 1'b1;
        else       result = ax / bx;
      end
      MOD: begin
        if (bzero) err = 1'b1;
        else       result = ax % bx;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_exec_queue.sv
// In-order instruction queue storing precomputed ALU results.
// Valid/ready on both ends, peek port, flush, saturating drop count.
module instr_exec_queue
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH   = 32,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DROP_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset_en,
  input  logic                           flush,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  opcode_t                        wr_opcode,
  input  logic signed [OP_WIDTH-1:0]     wr_operand_a,
  input  logic signed [OP_WIDTH-1:0]     wr_operand_b,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output opcode_t                        rd_opcode,
  output logic signed [OP_WIDTH-1:0]     rd_operand_a,
  output logic signed [OP_WIDTH-1:0]     rd_operand_b,
  output logic signed [2*OP_WIDTH-1:0]   rd_result,
  output logic                           rd_err,
  input  logic [$clog2(DEPTH)-1:0]       peek_index,
  output logic                           peek_valid,
  output opcode_t                        peek_opcode,
  output logic signed [OP_WIDTH-1:0]     peek_operand_a,
  output logic signed [OP_WIDTH-1:0]     peek_operand_b,
  output logic signed [2*OP_WIDTH-1:0]   peek_result,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DROP_CNT_W-1:0]          drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 2 * OP_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_exec_queue: DEPTH must be a power of 2 and >= 2");
  end

  opcode_t                     op_q  [DEPTH];
  logic signed [OP_WIDTH-1:0]  a_q   [DEPTH];
  logic signed [OP_WIDTH-1:0]  b_q   [DEPTH];
  logic signed [RW-1:0]        res_q [DEPTH];
  logic [DEPTH-1:0]            err_q;

  logic [PW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  full, empty, push, pop, drop;
  logic [PW-1:0]         peek_addr;
  logic signed [RW-1:0]  alu_res;
  logic                  alu_err;

  instr_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opcode (wr_opcode),
    .a      (wr_operand_a),
    .b      (wr_operand_b),
    .result (alu_res),
    .err    (alu_err)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full && !flush;
  assign rd_valid = !empty;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready && !flush;
  assign drop     = wr_valid && full && !flush;

  assign rd_opcode    = op_q[head_q];
  assign rd_operand_a = a_q[head_q];
  assign rd_operand_b = b_q[head_q];
  assign rd_result    = res_q[head_q];
  assign rd_err       = err_q[head_q];

  assign peek_addr      = head_q + peek_index;
  assign peek_valid     = (CW'(peek_index) < count_q);
  assign peek_opcode    = op_q[peek_addr];
  assign peek_operand_a = a_q[peek_addr];
  assign peek_operand_b = b_q[peek_addr];
  assign peek_result    = res_q[peek_addr];

  assign count    = count_q;
  assign drop_cnt = drop_q;

  // Next occupancy and saturating drop count
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    drop_d  = drop_q;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  // Pointer, occupancy and storage update
  always_ff @(posedge clk) begin
    if (reset_en) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      err_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= ZERO;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        res_q[i] <= '0;
      end
    end else begin
      drop_q <= drop_d;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        count_q <= count_d;
        if (pop) head_q <= head_q + 1'b1;
        if (push) begin
          op_q[tail_q]  <= wr_opcode;
          a_q[tail_q]   <= wr_operand_a;
          b_q[tail_q]   <= wr_operand_b;
          res_q[tail_q] <= alu_res;
          err_q[tail_q] <= alu_err;
          tail_q        <= tail_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_exec_queue.sv
// Scoreboard bench for instr_exec_queue.
// Expected entries are queued on push and compared on pop.
module tb_instr_exec_queue;
  import instr_register_pkg::*;

  localparam int D = 8;

  typedef struct {
    opcode_t op;
    int      a;
    int      b;
    longint  r;
    bit      e;
  } exp_t;

  logic        clk = 0;
  logic        reset_en = 1;
  logic        flush = 0;
  logic        wr_valid = 0;
  logic        wr_ready;
  opcode_t     wr_opcode = ZERO;
  logic signed [31:0] wr_operand_a = 0;
  logic signed [31:0] wr_operand_b = 0;
  logic        rd_valid;
  logic        rd_ready = 0;
  opcode_t     rd_opcode;
  logic signed [31:0] rd_operand_a, rd_operand_b;
  logic signed [63:0] rd_result;
  logic        rd_err;
  logic [2:0]  peek_index = 0;
  logic        peek_valid;
  opcode_t     peek_opcode;
  logic signed [31:0] peek_operand_a, peek_operand_b;
  logic signed [63:0] peek_result;
  logic [3:0]  count;
  logic [15:0] drop_cnt;

  exp_t   q[$];
  int     checks = 0;
  int     failures = 0;
  int     exp_drop = 0;

  always #5 clk = ~clk;

  instr_exec_queue #(.OP_WIDTH(32), .DEPTH(D), .DROP_CNT_W(16)) dut (
    .clk(clk), .reset_en(reset_en), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_opcode(wr_opcode),
    .wr_operand_a(wr_operand_a), .wr_operand_b(wr_operand_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_opcode(rd_opcode),
    .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
    .rd_result(rd_result), .rd_err(rd_err),
    .peek_index(peek_index), .peek_valid(peek_valid),
    .peek_opcode(peek_opcode),
    .peek_operand_a(peek_operand_a), .peek_operand_b(peek_operand_b),
    .peek_result(peek_result),
    .count(count), .drop_cnt(drop_cnt)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(opcode_t op, int a, int b);
    exp_t x;
    x.op = op; x.a = a; x.b = b; x.r = 0; x.e = 0;
    case (op)
      ZERO:  x.r = 0;
      PASSA: x.r = a;
      PASSB: x.r = b;
      ADD:   x.r = longint'(a) + longint'(b);
      SUB:   x.r = longint'(a) - longint'(b);
      MULT:  x.r = longint'(a) * longint'(b);
      DIV:   if (b == 0) x.e = 1; else x.r = longint'(a) / longint'(b);
      MOD:   if (b == 0) x.e = 1; else x.r = longint'(a) % longint'(b);
      default: x.r = 0;
    endcase
    return x;
  endfunction

  // One clock: drive at negedge, score, advance to the next negedge
  task automatic cyc(bit push, opcode_t op, int a, int b,
                     bit pop, bit fl = 0);
    bit   full, emp;
    exp_t e;
    wr_valid = push; wr_opcode = op;
    wr_operand_a = a; wr_operand_b = b;
    rd_ready = pop; flush = fl;
    #1;
    full = (q.size() == D);
    emp  = (q.size() == 0);
    chk("wr_ready", 64'(wr_ready), 64'(!full && !fl));
    chk("rd_valid", 64'(rd_valid), 64'(!emp));
    if (pop && !emp && !fl) begin
      e = q.pop_front();
      chk("rd_opcode", 64'(rd_opcode), 64'(e.op));
      chk("rd_op_a", 64'(rd_operand_a), 64'(e.a));
      chk("rd_op_b", 64'(rd_operand_b), 64'(e.b));
      chk("rd_result", rd_result, e.r);
      chk("rd_err", 64'(rd_err), 64'(e.e));
    end
    if (push && full && !fl && exp_drop != 16'hFFFF) exp_drop++;
    if (fl) q.delete();
    else if (push && !full) q.push_back(model(op, a, b));
    @(negedge clk);
    wr_valid = 0; rd_ready = 0; flush = 0;
    #1;
    chk("count", 64'(count), 64'(q.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic idle_chk_zero();
    chk("rst_rd_valid", 64'(rd_valid), 0);
    chk("rst_wr_ready", 64'(wr_ready), 1);
    chk("rst_count", 64'(count), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_peek_valid", 64'(peek_valid), 0);
    chk("rst_rd_opcode", 64'(rd_opcode), 0);
    chk("rst_rd_a", 64'(rd_operand_a), 0);
    chk("rst_rd_b", 64'(rd_operand_b), 0);
    chk("rst_rd_result", rd_result, 0);
    chk("rst_rd_err", 64'(rd_err), 0);
    chk("rst_peek_result", peek_result, 0);
    chk("rst_peek_a", 64'(peek_operand_a), 0);
  endtask

  initial begin
    // Reset then idle
    reset_en = 1;
    repeat (2) @(negedge clk);
    reset_en = 0;
    #1;
    idle_chk_zero();
    @(negedge clk);

    // Single push/pop: 5 + -7
    cyc(1, ADD, 5, -7, 0);
    chk("add_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_err", 64'(rd_err), 0);
    cyc(0, ZERO, 0, 0, 1);
    chk("pop_rd_valid", 64'(rd_valid), 0);

    // Fill and overflow
    for (int i = 0; i < 8; i++) cyc(1, MULT, i, 3, 0);
    for (int i = 0; i < 3; i++) cyc(1, MULT, 99, 3, 0);
    chk("full_count", 64'(count), 8);
    chk("full_wr_ready", 64'(wr_ready), 0);
    chk("full_drop", 64'(drop_cnt), 3);
    peek_index = 3'd5;
    #1;
    chk("peek_valid", 64'(peek_valid), 1);
    chk("peek_result", peek_result, 15);
    chk("peek_opcode", 64'(peek_opcode), 64'(MULT));
    peek_index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_result", rd_result, 64'(i * 3));
      cyc(0, ZERO, 0, 0, 1);
    end

    // Wrap with simultaneous push/pop
    for (int i = 0; i < 6; i++) cyc(1, SUB, i, 100, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, ADD, 1000 + i, -i, 1);
      chk("wrap_count", 64'(count), 6);
    end
    chk("wrap_drop", 64'(drop_cnt), 3);
    while (q.size() > 0) cyc(0, ZERO, 0, 0, 1);

    // Divide / modulo
    cyc(1, DIV, 9, 0, 0);
    cyc(1, MOD, -7, 2, 0);
    cyc(1, DIV, -7, 2, 0);
    chk("div0_result", rd_result, 0);
    chk("div0_err", 64'(rd_err), 1);
    cyc(0, ZERO, 0, 0, 1);
    chk("mod_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mod_err", 64'(rd_err), 0);
    cyc(0, ZERO, 0, 0, 1);
    chk("div_result", rd_result, 64'hFFFF_FFFF_FFFF_FFFD);
    cyc(0, ZERO, 0, 0, 1);

    // Flush with concurrent push
    for (int i = 0; i < 4; i++) cyc(1, PASSB, 0, i + 40, 0);
    cyc(1, PASSA, 77, 0, 1, 1);
    chk("flush_count", 64'(count), 0);
    chk("flush_rd_valid", 64'(rd_valid), 0);
    chk("flush_drop", 64'(drop_cnt), 3);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, PASSA, i + 1, 0, 0);
    reset_en = 1;
    @(negedge clk);
    reset_en = 0;
    q.delete();
    exp_drop = 0;
    #1;
    chk("rst_mid_count", 64'(count), 0);
    chk("rst_mid_rd_valid", 64'(rd_valid), 0);
    chk("rst_mid_drop", 64'(drop_cnt), 0);
    cyc(1, PASSB, 0, 11, 0);
    cyc(0, ZERO, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
